ntt_radix_gentleman_sande_bypass: RTL and testbench
===================================================

Name: ntt_radix_gentleman_sande_bypass

Overview:
- Fake Gentleman-Sande (decimation-in-frequency) radix-R butterfly for simulation benches of the MDC/cluster network.
- It is the inverse-direction counterpart of the fake Cooley-Tukey butterfly. It sits at the GS positions of the backward NTT path.
- It performs no arithmetic. It delays data by a parameterised latency and optionally converts reverse2 input order to natural order.
- It tags each output beat with a stage-local beat index and start/end-of-burst flags so benches can check network routing.

Parameters:
- R, 8, radix. Power of 2, ≥2.
- OP_W, 32, coefficient width.
- OMG_SEL_NB, 2, number of omega sets. Ports only; values are unused.
- LAT, 3, pipeline latency in cycles, ≥1.
- SIDE_W, 0, side data width. 0 means unused.
- IN_NATURAL_ORDER, 0, input order. (0) reverse2, (1) natural. Output is always natural.
- BEAT_NB, 4, beats per burst, ≥1.
- OMG_SEL_W, localparam, OMG_SEL_NB==1 ? 1 : $clog2(OMG_SEL_NB).
- BEAT_W, localparam, BEAT_NB==1 ? 1 : $clog2(BEAT_NB).

Ports:
- clk  in  1  clock.
- s_rst  in  1  synchronous reset, active-high.
- xf_a  in  R*OP_W  input coefficients, [R-1:0][OP_W-1:0].
- xt_a  out  R*OP_W  output coefficients.
- phi_a  in  (R-1)*OP_W  twiddles. Ignored.
- omg_a  in  OMG_SEL_NB*(R/2)*OP_W  omega roots. Ignored.
- omg_sel  in  OMG_SEL_W  omega selector. Ignored.
- in_avail  in  1  input beat valid.
- out_avail  out  1  output beat valid.
- in_side  in  max(SIDE_W,1)  side data accompanying the beat.
- out_side  out  max(SIDE_W,1)  delayed side data.
- out_beat_id  out  BEAT_W  index of the output beat within its burst.
- out_sob  out  1  first beat of burst.
- out_eob  out  1  last beat of burst.
- out_err  out  1  sticky error flag.

Behaviour:
- Reset values:
  - out_avail=0, out_sob=0, out_eob=0, out_beat_id=0, out_err=0.
  - All LAT valid stages are cleared.
  - Data and side pipes are not reset. Their value is don't-care while out_avail=0.
- Reorder:
  - When IN_NATURAL_ORDER=0, xt_a[i] = xf_a[bitrev_log2R(i)]. Example for R=8: out[1]=in[4], out[3]=in[6].
  - When IN_NATURAL_ORDER=1, this is the identity mapping.
  - Reorder is applied combinationally at pipe entry.
- Pipeline:
  - The pipe is a LAT-deep shift register of {valid, data, side, beat_id, sob, eob}. It advances every cycle; there is no backpressure.
  - A beat entering at cycle t appears at t+LAT with out_avail=1.
  - in_avail gaps propagate unchanged.
  - Back-to-back beats are sustained at 1 beat/cycle.
- Beat counter:
  - The counter is BEAT_W wide and runs at pipe entry. It increments on each in_avail.
  - It wraps to 0 after BEAT_NB-1.
  - sob is set when count==0; eob is set when count==BEAT_NB-1. When BEAT_NB=1, sob=eob=1 on every beat.
  - The counter does not advance on idle cycles, so a burst may span gaps.
- Error monitor:
  - out_err is set when in_avail=1 while any of omg_sel, phi_a, or omg_a contains X/Z. This check is simulation-only and uses $isunknown.
  - out_err is also set when omg_sel ≥ OMG_SEL_NB.
  - Once set, out_err stays high until s_rst.
- Reset mid-operation: asserting s_rst clears the valid pipe and the counter in the same edge. Beats in flight are dropped; no out_avail follows from them.
- Simultaneous events:
  - When s_rst and in_avail are both high, reset wins and the beat is discarded.
  - When the counter wraps on the same cycle a new burst starts, the next beat gets sob.
- Reset value of out_side when SIDE_W=0: 1'b0, tied off.

Test Plan:
- R=8, LAT=3, IN_NATURAL_ORDER=1: drive one beat xf_a[i]=i+16 at t=0 -> out_avail=1 only at t=3, xt_a[i]=i+16, out_sob=1, out_beat_id=0.
- R=8, IN_NATURAL_ORDER=0: drive xf_a[i]=i -> xt_a = {7,3,5,1,6,2,4,0} (index 7 down to 0), i.e. xt_a[1]=4, xt_a[6]=3.
- BEAT_NB=4: drive 10 consecutive beats -> out_beat_id 0,1,2,3,0,1,2,3,0,1; out_sob on beats 0,4,8; out_eob on beats 3,7.
- Drive in_avail pattern 1,0,0,1,1 with LAT=2 -> out_avail pattern 1,0,0,1,1 delayed by 2 cycles; beat_id 0,1,2 (ids skip the gaps).
- Drive 3 beats, then assert s_rst for 1 cycle while 2 beats are in flight -> no out_avail afterwards; the next input beat gets out_beat_id=0, out_sob=1.
- OMG_SEL_NB=3, drive omg_sel=3 with in_avail=1 -> out_err=1 on the next cycle and held; it clears only after s_rst.

Source files
------------

// File: rtl/ntt_radix_gentleman_sande_bypass.sv
// Bypass Gentleman-Sande butterfly: no arithmetic, just an optional reverse2-to-natural
// reorder, a fixed-latency pipe, and burst tagging for network-routing benches.
module ntt_radix_gentleman_sande_bypass #(
  parameter int unsigned R                = 8,
  parameter int unsigned OP_W             = 32,
  parameter int unsigned OMG_SEL_NB       = 2,
  parameter int unsigned LAT              = 3,
  parameter int unsigned SIDE_W           = 0,
  parameter int unsigned IN_NATURAL_ORDER = 0,
  parameter int unsigned BEAT_NB          = 4
) (
  input  logic                                                   clk,
  input  logic                                                   s_rst,
  input  logic [R-1:0][OP_W-1:0]                                 xf_a,
  output logic [R-1:0][OP_W-1:0]                                 xt_a,
  input  logic [(R-1)*OP_W-1:0]                                  phi_a,
  input  logic [OMG_SEL_NB*(R/2)*OP_W-1:0]                       omg_a,
  input  logic [((OMG_SEL_NB == 1) ? 1 : $clog2(OMG_SEL_NB))-1:0] omg_sel,
  input  logic                                                   in_avail,
  output logic                                                   out_avail,
  input  logic [((SIDE_W == 0) ? 1 : SIDE_W)-1:0]                in_side,
  output logic [((SIDE_W == 0) ? 1 : SIDE_W)-1:0]                out_side,
  output logic [((BEAT_NB == 1) ? 1 : $clog2(BEAT_NB))-1:0]      out_beat_id,
  output logic                                                   out_sob,
  output logic                                                   out_eob,
  output logic                                                   out_err
);

  localparam int unsigned OMG_SEL_W = (OMG_SEL_NB == 1) ? 1 : $clog2(OMG_SEL_NB);
  localparam int unsigned BEAT_W    = (BEAT_NB == 1) ? 1 : $clog2(BEAT_NB);
  localparam int unsigned SIDE_PW   = (SIDE_W == 0) ? 1 : SIDE_W;
  localparam int unsigned LOG2R     = $clog2(R);

  function automatic logic [LOG2R-1:0] bitrev(input logic [LOG2R-1:0] idx);
    logic [LOG2R-1:0] res;
    res = '0;
    for (int b = 0; b < LOG2R; b++) res[b] = idx[LOG2R-1-b];
    return res;
  endfunction

  logic [R-1:0][OP_W-1:0] xf_ord;
  logic [BEAT_W-1:0]      cnt_q, cnt_d;
  logic                   sob_c, eob_c, err_c, err_q;

  logic                   vld_q [LAT];
  logic [BEAT_W-1:0]      id_q  [LAT];
  logic                   sob_q [LAT];
  logic                   eob_q [LAT];
  logic [R-1:0][OP_W-1:0] dat_q [LAT];

  // Reverse2 input lands in natural order before entering the pipe
  always_comb begin
    xf_ord = xf_a;
    if (IN_NATURAL_ORDER == 0) begin
      for (int i = 0; i < R; i++) xf_ord[i] = xf_a[bitrev(LOG2R'(i))];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sob_c = (cnt_q == '0);
    eob_c = (cnt_q == BEAT_W'(BEAT_NB - 1));
    if (in_avail) cnt_d = eob_c ? '0 : cnt_q + BEAT_W'(1);
  end

  // X/Z on the ignored twiddle ports is only observable in a 4-state simulator
  always_comb begin
    err_c = 1'b0;
    if (in_avail) begin
      if ($isunknown({omg_sel, phi_a, omg_a})) err_c = 1'b1;
      if (32'(omg_sel) >= OMG_SEL_NB) err_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (s_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        vld_q[k] <= 1'b0;
        id_q[k]  <= '0;
        sob_q[k] <= 1'b0;
        eob_q[k] <= 1'b0;
      end
    end else begin
      cnt_q    <= cnt_d;
      err_q    <= err_q | err_c;
      vld_q[0] <= in_avail;
      id_q[0]  <= cnt_q;
      sob_q[0] <= sob_c;
      eob_q[0] <= eob_c;
      for (int k = 1; k < LAT; k++) begin
        vld_q[k] <= vld_q[k-1];
        id_q[k]  <= id_q[k-1];
        sob_q[k] <= sob_q[k-1];
        eob_q[k] <= eob_q[k-1];
      end
    end
  end

  // Payload is qualified by the valid pipe, so it carries no reset
  always_ff @(posedge clk) begin
    dat_q[0] <= xf_ord;
    for (int k = 1; k < LAT; k++) dat_q[k] <= dat_q[k-1];
  end

  generate
    if (SIDE_W == 0) begin : g_noside
      logic unused_side;
      assign unused_side = ^in_side;
      assign out_side    = 1'b0;
    end else begin : g_side
      logic [SIDE_PW-1:0] side_q [LAT];
      always_ff @(posedge clk) begin
        side_q[0] <= in_side;
        for (int k = 1; k < LAT; k++) side_q[k] <= side_q[k-1];
      end
      assign out_side = side_q[LAT-1];
    end
  endgenerate

  assign xt_a        = dat_q[LAT-1];
  assign out_avail   = vld_q[LAT-1];
  assign out_beat_id = id_q[LAT-1];
  assign out_sob     = sob_q[LAT-1];
  assign out_eob     = eob_q[LAT-1];
  assign out_err     = err_q;

endmodule

// File: tb/tb_ntt_radix_gentleman_sande_bypass.sv
// Directed bench: three bypass instances with different latency/order/burst settings
// share one stimulus stream and are checked cycle by cycle.
module tb_ntt_radix_gentleman_sande_bypass;

  logic                clk;
  logic                s_rst;
  logic                in_avail;
  logic [7:0][31:0]    xf;
  logic [7*32-1:0]     phi;
  logic [3*4*32-1:0]   omg0;
  logic [2*4*32-1:0]   omg1;
  logic [1*4*32-1:0]   omg2;
  logic [1:0]          sel0;
  logic                sel1, sel2;
  logic [3:0]          side0;
  logic                side1, side2;

  logic [7:0][31:0]    xt0, xt1, xt2;
  logic                av0, av1, av2;
  logic [3:0]          so0;
  logic                so1, so2;
  logic [1:0]          id0, id1;
  logic [0:0]          id2;
  logic                sob0, sob1, sob2, eob0, eob1, eob2, err0, err1, err2;

  int n_chk  = 0;
  int n_fail = 0;

  int unsigned rev_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  bit          gap_pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  int unsigned gap_id  [5] = '{0, 0, 0, 1, 2};

  ntt_radix_gentleman_sande_bypass #(
    .R(8), .OP_W(32), .OMG_SEL_NB(3), .LAT(3), .SIDE_W(4), .IN_NATURAL_ORDER(1), .BEAT_NB(4)
  ) u0 (
    .clk(clk), .s_rst(s_rst), .xf_a(xf), .xt_a(xt0), .phi_a(phi), .omg_a(omg0),
    .omg_sel(sel0), .in_avail(in_avail), .out_avail(av0), .in_side(side0), .out_side(so0),
    .out_beat_id(id0), .out_sob(sob0), .out_eob(eob0), .out_err(err0)
  );

  ntt_radix_gentleman_sande_bypass #(
    .R(8), .OP_W(32), .OMG_SEL_NB(2), .LAT(2), .SIDE_W(0), .IN_NATURAL_ORDER(0), .BEAT_NB(4)
  ) u1 (
    .clk(clk), .s_rst(s_rst), .xf_a(xf), .xt_a(xt1), .phi_a(phi), .omg_a(omg1),
    .omg_sel(sel1), .in_avail(in_avail), .out_avail(av1), .in_side(side1), .out_side(so1),
    .out_beat_id(id1), .out_sob(sob1), .out_eob(eob1), .out_err(err1)
  );

  ntt_radix_gentleman_sande_bypass #(
    .R(8), .OP_W(32), .OMG_SEL_NB(1), .LAT(1), .SIDE_W(0), .IN_NATURAL_ORDER(1), .BEAT_NB(1)
  ) u2 (
    .clk(clk), .s_rst(s_rst), .xf_a(xf), .xt_a(xt2), .phi_a(phi), .omg_a(omg2),
    .omg_sel(sel2), .in_avail(in_avail), .out_avail(av2), .in_side(side2), .out_side(so2),
    .out_beat_id(id2), .out_sob(sob2), .out_eob(eob2), .out_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [7:0][31:0] obs,
                           input int unsigned base, input bit rev);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s[%0d]", tag, i), 64'(obs[i]),
          64'(base + (rev ? rev_tab[i] : 32'(i))));
    end
  endtask

  task automatic do_reset();
    s_rst    = 1'b1;
    in_avail = 1'b0;
    step();
    step();
    s_rst = 1'b0;
  endtask

  initial begin
    xf = '0; phi = '0; omg0 = '0; omg1 = '0; omg2 = '0;
    sel0 = '0; sel1 = 1'b0; sel2 = 1'b0;
    side0 = '0; side1 = 1'b0; side2 = 1'b0;
    in_avail = 1'b0;
    do_reset();
    step();

    // Reset state
    chk("rst_av0", 64'(av0), 64'(0));
    chk("rst_av1", 64'(av1), 64'(0));
    chk("rst_av2", 64'(av2), 64'(0));
    chk("rst_sob0", 64'(sob0), 64'(0));
    chk("rst_eob0", 64'(eob0), 64'(0));
    chk("rst_id0", 64'(id0), 64'(0));
    chk("rst_err0", 64'(err0), 64'(0));
    chk("rst_side1", 64'(so1), 64'(0));

    // Single beat: latency per instance, natural vs reverse2 lanes
    for (int i = 0; i < 8; i++) xf[i] = 32'(i + 16);
    side0 = 4'h5;
    in_avail = 1'b1;
    step();
    in_avail = 1'b0;
    chk("t1_av2", 64'(av2), 64'(1));
    chk("t1_sob2", 64'(sob2), 64'(1));
    chk("t1_eob2", 64'(eob2), 64'(1));
    chk_lanes("t1_xt2", xt2, 16, 1'b0);
    chk("t1_av1_early", 64'(av1), 64'(0));
    chk("t1_av0_early", 64'(av0), 64'(0));
    step();
    chk("t1_av1", 64'(av1), 64'(1));
    chk("t1_id1", 64'(id1), 64'(0));
    chk("t1_sob1", 64'(sob1), 64'(1));
    chk("t1_eob1", 64'(eob1), 64'(0));
    chk_lanes("t1_xt1", xt1, 16, 1'b1);
    chk("t1_av2_off", 64'(av2), 64'(0));
    chk("t1_av0_early2", 64'(av0), 64'(0));
    step();
    chk("t1_av0", 64'(av0), 64'(1));
    chk("t1_id0", 64'(id0), 64'(0));
    chk("t1_sob0", 64'(sob0), 64'(1));
    chk("t1_eob0", 64'(eob0), 64'(0));
    chk("t1_side0", 64'(so0), 64'(5));
    chk_lanes("t1_xt0", xt0, 16, 1'b0);
    chk("t1_av1_off", 64'(av1), 64'(0));
    step();
    chk("t1_av0_off", 64'(av0), 64'(0));

    // Reverse2 reorder with xf[i]=i
    do_reset();
    for (int i = 0; i < 8; i++) xf[i] = 32'(i);
    in_avail = 1'b1;
    step();
    in_avail = 1'b0;
    step();
    chk("t2_av1", 64'(av1), 64'(1));
    chk_lanes("t2_xt1", xt1, 0, 1'b1);
    chk("t2_side1", 64'(so1), 64'(0));
    step();

    // Ten back-to-back beats: beat id wrap and sob/eob
    do_reset();
    for (int c = 0; c < 13; c++) begin
      int j0, j1, j2;
      in_avail = (c < 10);
      for (int i = 0; i < 8; i++) xf[i] = 32'(c * 100 + i);
      side0 = 4'(c);
      step();
      j0 = c - 2;
      j1 = c - 1;
      j2 = c;
      if (j0 >= 0 && j0 < 10) begin
        chk($sformatf("t3_av0_b%0d", j0), 64'(av0), 64'(1));
        chk($sformatf("t3_id0_b%0d", j0), 64'(id0), 64'(j0 % 4));
        chk($sformatf("t3_sob0_b%0d", j0), 64'(sob0), 64'(j0 % 4 == 0));
        chk($sformatf("t3_eob0_b%0d", j0), 64'(eob0), 64'(j0 % 4 == 3));
        chk($sformatf("t3_lane0_b%0d", j0), 64'(xt0[0]), 64'(j0 * 100));
        chk($sformatf("t3_lane7_b%0d", j0), 64'(xt0[7]), 64'(j0 * 100 + 7));
        chk($sformatf("t3_side0_b%0d", j0), 64'(so0), 64'(j0));
      end else begin
        chk($sformatf("t3_av0_idle_c%0d", c), 64'(av0), 64'(0));
      end
      if (j1 >= 0 && j1 < 10) begin
        chk($sformatf("t3_id1_b%0d", j1), 64'(id1), 64'(j1 % 4));
        chk($sformatf("t3_lane1_b%0d", j1), 64'(xt1[1]), 64'(j1 * 100 + 4));
      end else begin
        chk($sformatf("t3_av1_idle_c%0d", c), 64'(av1), 64'(0));
      end
      if (j2 < 10) begin
        chk($sformatf("t3_sob2_b%0d", j2), 64'(sob2), 64'(1));
        chk($sformatf("t3_eob2_b%0d", j2), 64'(eob2), 64'(1));
        chk($sformatf("t3_id2_b%0d", j2), 64'(id2), 64'(0));
      end else begin
        chk($sformatf("t3_av2_idle_c%0d", c), 64'(av2), 64'(0));
      end
    end
    in_avail = 1'b0;

    // Gapped input: gaps propagate, ids do not advance on idle cycles
    do_reset();
    for (int c = 0; c < 8; c++) begin
      int j1, j0;
      bit e1, e0;
      in_avail = (c < 5) ? gap_pat[c] : 1'b0;
      step();
      j1 = c - 1;
      j0 = c - 2;
      e1 = (j1 >= 0 && j1 < 5) ? gap_pat[j1] : 1'b0;
      e0 = (j0 >= 0 && j0 < 5) ? gap_pat[j0] : 1'b0;
      chk($sformatf("t4_av1_c%0d", c), 64'(av1), 64'(e1));
      if (e1) chk($sformatf("t4_id1_c%0d", c), 64'(id1), 64'(gap_id[j1]));
      chk($sformatf("t4_av0_c%0d", c), 64'(av0), 64'(e0));
      if (e0) chk($sformatf("t4_id0_c%0d", c), 64'(id0), 64'(gap_id[j0]));
    end
    in_avail = 1'b0;

    // Reset while beats are in flight, with a simultaneous input beat
    do_reset();
    in_avail = 1'b1;
    step();
    step();
    step();
    chk("t5_av0_pre", 64'(av0), 64'(1));
    chk("t5_id0_pre", 64'(id0), 64'(0));
    s_rst = 1'b1;
    step();
    s_rst = 1'b0;
    in_avail = 1'b0;
    chk("t5_av0_rst", 64'(av0), 64'(0));
    chk("t5_av1_rst", 64'(av1), 64'(0));
    chk("t5_av2_rst", 64'(av2), 64'(0));
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("t5_av0_drop_c%0d", c), 64'(av0), 64'(0));
      chk($sformatf("t5_av1_drop_c%0d", c), 64'(av1), 64'(0));
    end
    in_avail = 1'b1;
    step();
    in_avail = 1'b0;
    chk("t5_av2_new", 64'(av2), 64'(1));
    step();
    chk("t5_av1_new", 64'(av1), 64'(1));
    chk("t5_id1_new", 64'(id1), 64'(0));
    chk("t5_sob1_new", 64'(sob1), 64'(1));
    step();
    chk("t5_av0_new", 64'(av0), 64'(1));
    chk("t5_id0_new", 64'(id0), 64'(0));
    chk("t5_sob0_new", 64'(sob0), 64'(1));

    // Omega selector range: last legal value, then out of range, sticky until reset
    do_reset();
    sel0 = 2'd2;
    in_avail = 1'b1;
    step();
    chk("t6_err0_legal", 64'(err0), 64'(0));
    sel0 = 2'd3;
    sel2 = 1'b1;
    step();
    sel0 = 2'd0;
    sel2 = 1'b0;
    in_avail = 1'b0;
    chk("t6_err0_set", 64'(err0), 64'(1));
    chk("t6_err2_set", 64'(err2), 64'(1));
    chk("t6_err1_clean", 64'(err1), 64'(0));
    step();
    step();
    chk("t6_err0_held", 64'(err0), 64'(1));
    chk("t6_err2_held", 64'(err2), 64'(1));
    s_rst = 1'b1;
    step();
    chk("t6_err0_rst", 64'(err0), 64'(0));
    s_rst = 1'b0;
    step();
    chk("t6_err0_after", 64'(err0), 64'(0));
    chk("t6_err2_after", 64'(err2), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
